// File: rtl/subtractor_32_seq.sv
// Multi-cycle unsigned subtractor: a - b - borrow_in, one CHUNK-bit slice per clock, LSB first.
// Optional signed-overflow flag enabled by defining SUBTRACTOR_32_SEQ_OVF_EN.
module subtractor_32_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow_out,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg, d_reg, d_next;
    logic              brw_reg, borrow_out_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CHUNK-1:0]  a_slice [NCHUNK];
    logic [CHUNK-1:0]  b_slice [NCHUNK];
    logic [CHUNK:0]    diff;
    logic              last_slice;

    // Slice views of the latched operands, and the difference vector with the active slice replaced.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
            assign d_next[gi*CHUNK +: CHUNK] = (idx_reg == IDX_W'(gi)) ? diff[CHUNK-1:0]
                                                                        : d_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // The extra top bit of the CHUNK+1 result is the borrow into the next slice.
    assign diff       = {1'b0, a_slice[idx_reg]} - {1'b0, b_slice[idx_reg]} - {{CHUNK{1'b0}}, brw_reg};
    assign last_slice = (idx_reg == IDX_W'(NCHUNK - 1));

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (in_valid)   state_next = BUSY;
            BUSY:    if (last_slice) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            d_reg          <= '0;
            brw_reg        <= 1'b0;
            borrow_out_reg <= 1'b0;
            idx_reg        <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (in_valid) begin
                    a_reg          <= a;
                    b_reg          <= b;
                    brw_reg        <= borrow_in;
                    d_reg          <= '0;
                    idx_reg        <= '0;
                    borrow_out_reg <= 1'b0;
                end
                BUSY: begin
                    d_reg   <= d_next;
                    brw_reg <= diff[CHUNK];
                    idx_reg <= last_slice ? '0 : idx_reg + IDX_W'(1);
                    if (last_slice) borrow_out_reg <= diff[CHUNK];
                end
                default: ;
            endcase
        end
    end

`ifdef SUBTRACTOR_32_SEQ_OVF_EN
    logic ovf_reg;

    // Operand signs differ and the result sign departs from the minuend: evaluated on the top slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == BUSY && last_slice) begin
            ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) & (diff[CHUNK-1] != a_reg[WIDTH-1]);
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign d          = d_reg;
    assign borrow_out = borrow_out_reg;

endmodule
